universal_shift_engine: RTL and testbench
=========================================

UNIVERSAL_SHIFT_ENGINE -- requirements
Module: universal_shift_engine

Interface
REQ-001 Parameter WIDTH, 8, data register width in bits (>=2) SHALL be provided.
REQ-002 Parameter AMT_W, 4, shift-count width in bits SHALL be provided.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  operation request, sampled each rising edge.
REQ-006 mode  input  3  operation select, captured on accept.
REQ-007 amt  input  AMT_W  shift count, captured on accept.
REQ-008 din  input  WIDTH  parallel load data, used by LOAD only.
REQ-009 sin_l  input  1  serial fill bit entering the LSB on SHL.
REQ-010 sin_r  input  1  serial fill bit entering the MSB on SHR.
REQ-011 q  output  WIDTH  data register.
REQ-012 sout  output  1  last bit shifted or rotated out.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 Mode encoding SHALL be: 0 HOLD, 1 LOAD, 2 SHL (fill sin_l), 3 SHR (fill sin_r), 4 ASR (fill q[WIDTH-1]), 5 ROL, 6 ROR, 7 reserved (treated as HOLD).
REQ-016 FSM states SHALL be IDLE, RUN and DONE; busy = (state != IDLE).
REQ-017 start SHALL be accepted only on an edge where state==IDLE and rst==0; start while busy (RUN or DONE) SHALL be ignored, not queued.
REQ-018 On accept, mode and amt SHALL be latched internally; later changes on mode/amt SHALL NOT affect the operation in flight.
REQ-019 LOAD: q<=din on the accept edge; next state DONE.
REQ-020 HOLD, reserved, or any shift/rotate mode with amt==0: q unchanged on the accept edge; next state DONE.
REQ-021 Shift/rotate with amt>0: accept edge SHALL load count<=amt and go to RUN, leaving q unchanged.
REQ-022 In RUN, each edge SHALL perform exactly one 1-bit shift/rotate on q and decrement count; the edge where count==1 SHALL go to DONE.
REQ-023 Total latency SHALL be amt shift edges after the accept edge; done SHALL be high for exactly the single cycle in DONE, after which the FSM returns to IDLE.
REQ-024 sin_l/sin_r SHALL be sampled on each individual shift edge, allowing a serial stream.
REQ-025 sout SHALL capture the bit leaving q on every shift edge (q[WIDTH-1] for SHL/ROL, q[0] for SHR/ASR/ROR) and hold it otherwise.
REQ-026 amt >= WIDTH SHALL be legal: shifts keep filling bit by bit, rotates wrap modulo WIDTH, still taking amt cycles.
REQ-027 In IDLE with no accept, q and sout SHALL hold.

Reset
REQ-028 rst SHALL take priority over start and all FSM activity, including mid-RUN.
REQ-029 On an rst edge: q=0, sout=0, count=0, state=IDLE, busy=0, done=0; an aborted operation SHALL NOT produce a done pulse.

Verification (WIDTH=8, AMT_W=4)
REQ-030 LOAD din=0xA5 -> q=0xA5 after accept edge, done=1 for the next cycle only, busy=0 after that.
REQ-031 After LOAD 0xA5, SHL amt=3 with sin_l=1 -> q steps 0x4B, 0x97, 0x2F; sout=1; done one cycle after the third shift.
REQ-032 LOAD 0x90, ASR amt=2 -> q 0xC8 then 0xE4; sout=0.
REQ-033 LOAD 0x81, ROR amt=9 -> 9 shift cycles, final q=0xC0, sout=1.
REQ-034 SHR amt=0 -> q unchanged, done the cycle after accept; start pulsed during a RUN of amt=5 is ignored, with exactly one done pulse.
REQ-035 rst asserted during the 2nd cycle of RUN -> next edge q=0x00, sout=0, busy=0, and no done pulse.

Source files
------------

// File: rtl/universal_shift_engine.sv
// Sequenced shift/rotate engine: one request loads, holds, or shifts/rotates q one bit per clock.
// A request is taken only while idle; done pulses for one cycle when the operation finishes.
module universal_shift_engine #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] din,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2:0] M_LOAD = 3'd1;
   localparam logic [2:0] M_SHL  = 3'd2;
   localparam logic [2:0] M_SHR  = 3'd3;
   localparam logic [2:0] M_ASR  = 3'd4;
   localparam logic [2:0] M_ROL  = 3'd5;
   localparam logic [2:0] M_ROR  = 3'd6;

   state_t           state, state_nxt;
   logic [2:0]       mode_r;
   logic [AMT_W-1:0] count;
   logic             accept;
   logic             is_shift;
   logic [WIDTH-1:0] shift_q;
   logic             shift_bit;

   assign accept   = (state == IDLE) && start;
   assign is_shift = (mode >= M_SHL) && (mode <= M_ROR);

   // One-bit step of the latched operation; fill bits are sampled live every edge.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      shift_q   = q;
      shift_bit = sout;
      case (mode_r)
         M_SHL: begin shift_q = {q[WIDTH-2:0], sin_l};      shift_bit = q[WIDTH-1]; end
         M_SHR: begin shift_q = {sin_r, q[WIDTH-1:1]};      shift_bit = q[0];       end
         M_ASR: begin shift_q = {q[WIDTH-1], q[WIDTH-1:1]}; shift_bit = q[0];       end
         M_ROL: begin shift_q = {q[WIDTH-2:0], q[WIDTH-1]}; shift_bit = q[WIDTH-1]; end
         M_ROR: begin shift_q = {q[0], q[WIDTH-1:1]};       shift_bit = q[0];       end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE: if (start) state_nxt = (is_shift && amt != '0) ? RUN : DONE;
         RUN:  if (count == AMT_W'(1)) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= '0;
         sout   <= 1'b0;
         count  <= '0;
         mode_r <= '0;
      end else if (accept) begin
         mode_r <= mode;
         count  <= amt;
         if (mode == M_LOAD) q <= din;
      end else if (state == RUN) begin
         q     <= shift_q;
         sout  <= shift_bit;
         count <= count - AMT_W'(1);
      end
   end

endmodule

// File: tb/tb_universal_shift_engine.sv
// Directed self-checking bench for universal_shift_engine (WIDTH=8, AMT_W=4).
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_universal_shift_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [3:0] amt = 4'd0;
   logic [7:0] din = 8'h00;
   logic       sin_l = 1'b0;
   logic       sin_r = 1'b0;
   logic [7:0] q;
   logic       sout, busy, done;

   int checks = 0;
   int failures = 0;
   int done_count;

   universal_shift_engine #(.WIDTH(8), .AMT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt), .din(din),
      .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout(sout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic issue(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d);
      start = 1'b1; mode = m; amt = a; din = d;
      step();
      start = 1'b0; mode = 3'd7; amt = 4'd0; din = 8'h00;
   endtask

   task automatic load_and_finish(input logic [7:0] d);
      issue(3'd1, 4'd0, d);
      step();
   endtask

   initial begin
      // Reset
      step(); step();
      check("rst_q", q, 8'h00);
      check("rst_sout", sout, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst = 1'b0;
      step();
      check("idle_hold_q", q, 8'h00);

      // LOAD 0xA5
      issue(3'd1, 4'd0, 8'hA5);
      check("load_q", q, 8'hA5);
      check("load_done", done, 1'b1);
      check("load_busy", busy, 1'b1);
      step();
      check("load_done_clr", done, 1'b0);
      check("load_busy_clr", busy, 1'b0);
      check("load_q_hold", q, 8'hA5);

      // SHL amt=3, sin_l=1; mode/amt garbage after accept must not matter
      sin_l = 1'b1;
      issue(3'd2, 4'd3, 8'h00);
      check("shl_accept_q", q, 8'hA5);
      check("shl_accept_busy", busy, 1'b1);
      check("shl_accept_done", done, 1'b0);
      step();
      check("shl_q1", q, 8'h4B);
      check("shl_sout1", sout, 1'b1);
      step();
      check("shl_q2", q, 8'h97);
      check("shl_sout2", sout, 1'b0);
      check("shl_done_early", done, 1'b0);
      step();
      check("shl_q3", q, 8'h2F);
      check("shl_sout3", sout, 1'b1);
      check("shl_done", done, 1'b1);
      step();
      check("shl_done_clr", done, 1'b0);
      check("shl_busy_clr", busy, 1'b0);
      sin_l = 1'b0;

      // LOAD 0x90, ASR amt=2
      load_and_finish(8'h90);
      issue(3'd4, 4'd2, 8'h00);
      step();
      check("asr_q1", q, 8'hC8);
      step();
      check("asr_q2", q, 8'hE4);
      check("asr_sout", sout, 1'b0);
      check("asr_done", done, 1'b1);
      step();

      // LOAD 0x81, ROR amt=9 (wraps past WIDTH)
      load_and_finish(8'h81);
      issue(3'd6, 4'd9, 8'h00);
      for (int i = 1; i <= 8; i++) begin
         step();
         check("ror_running_busy", busy, 1'b1);
         check("ror_running_done", done, 1'b0);
      end
      step();
      check("ror_q", q, 8'hC0);
      check("ror_sout", sout, 1'b1);
      check("ror_done", done, 1'b1);
      step();

      // SHR amt=0: no shift, done right after accept
      sin_r = 1'b1;
      issue(3'd3, 4'd0, 8'h00);
      check("shr0_q", q, 8'hC0);
      check("shr0_done", done, 1'b1);
      step();
      check("shr0_idle", busy, 1'b0);
      sin_r = 1'b0;

      // ROL amt=5 on 0xC0 with a LOAD request pulsed mid-RUN (must be ignored)
      done_count = 0;
      issue(3'd5, 4'd5, 8'h00);
      step();
      start = 1'b1; mode = 3'd1; din = 8'hFF;
      step();
      start = 1'b0; mode = 3'd7; din = 8'h00;
      for (int i = 0; i < 10; i++) begin
         if (done) done_count++;
         step();
      end
      check("rol_q", q, 8'h18);
      check("rol_one_done", done_count, 1);
      check("rol_idle", busy, 1'b0);

      // Reset during the second RUN cycle: no done, everything cleared
      load_and_finish(8'hBC);
      issue(3'd2, 4'd4, 8'h00);
      step();
      check("abort_pre_q", q, 8'h78);
      check("abort_pre_sout", sout, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_q", q, 8'h00);
      check("abort_sout", sout, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      done_count = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) done_count++;
         step();
      end
      check("abort_no_done", done_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
